ctrl_pipe: RTL

Carries the 11-bit control word from the decode stage through the EX, MEM and WB pipeline registers, alongside the register indices each stage needs. Also detects hazards on that control stream. It inserts one bubble on a load-use dependency, kills the decode-stage instruction on a taken-branch flush, and drives operand forwarding selects for the EX stage. It sits directly downstream of the instruction decoder's `signals` output and feeds the datapath stage muxes.

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/ctrl_hazard.sv | 57 +++++
 rtl/ctrl_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the control-word pipeline.
// Control word bit map, memory-op encodings and forwarding-select encodings.
package ctrl_pkg;

    localparam int unsigned SIG_W_DEFAULT = 11;
    localparam int unsigned REG_W_DEFAULT = 4;

    localparam int unsigned SIG_ALU_LSB = 0;
    localparam int unsigned SIG_SEXT    = 3;
    localparam int unsigned SIG_IMM     = 4;
    localparam int unsigned SIG_CMP     = 5;
    localparam int unsigned SIG_MEM_LSB = 6;
    localparam int unsigned SIG_WB_MUX  = 8;
    localparam int unsigned SIG_REG_WE  = 9;
    localparam int unsigned SIG_FETCH   = 10;

    localparam logic [1:0] MEM_RD = 2'b10;
    localparam logic [1:0] MEM_WR = 2'b01;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

endpackage

// File: rtl/ctrl_hazard.sv
// ctrl_hazard: combinational load-use detection, decode handshake and
// EX-stage operand forwarding selects derived from pipeline stage state.
module ctrl_hazard
    import ctrl_pkg::*;
#(
    parameter int unsigned SIG_W = SIG_W_DEFAULT,
    parameter int unsigned REG_W = REG_W_DEFAULT
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [SIG_W-1:0] ex_signals,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] ex_rn,
    input  logic [REG_W-1:0] ex_rm,
    input  logic             mem_valid,
    input  logic [SIG_W-1:0] mem_signals,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic [SIG_W-1:0] wb_signals,
    input  logic [REG_W-1:0] wb_rd,
    output logic             hz,
    output logic             id_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    logic mem_wr_en;
    logic wb_wr_en;

    assign mem_wr_en = mem_valid && mem_signals[SIG_REG_WE];
    assign wb_wr_en  = wb_valid && wb_signals[SIG_REG_WE];

    // Load in EX whose destination feeds the decode-stage instruction
    always_comb begin
        hz = id_valid && ex_valid
             && (ex_signals[SIG_MEM_LSB +: 2] == MEM_RD)
             && ex_signals[SIG_REG_WE]
             && ((ex_rd == id_rn) || (ex_rd == id_rm));
        id_ready = flush || !hz;
    end

    // Forwarding selects, nearest producer (MEM) first
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_valid) begin
            if (mem_wr_en && (mem_rd == ex_rn))      fwd_a = FWD_MEM;
            else if (wb_wr_en && (wb_rd == ex_rn))   fwd_a = FWD_WB;
            if (mem_wr_en && (mem_rd == ex_rm))      fwd_b = FWD_MEM;
            else if (wb_wr_en && (wb_rd == ex_rm))   fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control word through EX/MEM/WB, inserting a
// bubble on load-use, killing decode on flush, and driving forwarding selects.
// Optional feature macro: CTRL_PIPE_STATS_EN adds saturating stall/flush counters.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned SIG_W = SIG_W_DEFAULT,
    parameter int unsigned REG_W = REG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [SIG_W-1:0] id_signals,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    output logic             id_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [SIG_W-1:0] ex_signals,
    output logic [SIG_W-1:0] mem_signals,
    output logic [SIG_W-1:0] wb_signals,
    output logic [REG_W-1:0] mem_rd,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`ifdef CTRL_PIPE_STATS_EN
   ,output logic [15:0]      stat_stalls,
    output logic [15:0]      stat_flushes
`endif
);

    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] ex_rn;
    logic [REG_W-1:0] ex_rm;
    logic             hz;
    logic             hz_ready;
    logic [1:0]       hz_fwd_a;
    logic [1:0]       hz_fwd_b;

    ctrl_hazard #(
        .SIG_W (SIG_W),
        .REG_W (REG_W)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_signals  (ex_signals),
        .ex_rd       (ex_rd),
        .ex_rn       (ex_rn),
        .ex_rm       (ex_rm),
        .mem_valid   (mem_valid),
        .mem_signals (mem_signals),
        .mem_rd      (mem_rd),
        .wb_valid    (wb_valid),
        .wb_signals  (wb_signals),
        .wb_rd       (wb_rd),
        .hz          (hz),
        .id_ready    (hz_ready),
        .fwd_a       (hz_fwd_a),
        .fwd_b       (hz_fwd_b)
    );

    // Reset overrides the handshake and selects so stale stage state never leaks out
    always_comb begin
        id_ready = rst || hz_ready;
        fwd_a    = rst ? FWD_RF : hz_fwd_a;
        fwd_b    = rst ? FWD_RF : hz_fwd_b;
    end

    // EX capture: flush, then load-use, then idle decode all yield a bubble
    always_ff @(posedge clk) begin
        if (rst || flush || hz || !id_valid) begin
            ex_valid   <= 1'b0;
            ex_signals <= '0;
            ex_rd      <= '0;
            ex_rn      <= '0;
            ex_rm      <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_signals <= id_signals;
            ex_rd      <= id_rd;
            ex_rn      <= id_rn;
            ex_rm      <= id_rm;
        end
    end

    // MEM and WB advance unconditionally every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid   <= 1'b0;
            mem_signals <= '0;
            mem_rd      <= '0;
            wb_valid    <= 1'b0;
            wb_signals  <= '0;
            wb_rd       <= '0;
        end else begin
            mem_valid   <= ex_valid;
            mem_signals <= ex_signals;
            mem_rd      <= ex_rd;
            wb_valid    <= mem_valid;
            wb_signals  <= mem_signals;
            wb_rd       <= mem_rd;
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    // Saturating event counters: stalls that actually cost a cycle, and killed decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stalls  <= '0;
            stat_flushes <= '0;
        end else begin
            if (hz && !flush && (stat_stalls != '1))
                stat_stalls <= stat_stalls + 16'd1;
            if (flush && id_valid && (stat_flushes != '1))
                stat_flushes <= stat_flushes + 16'd1;
        end
    end
`endif

endmodule
